// File: rtl/main_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : main_mem_ctrl_pkg
// Description : NOC packet layout and memory request/reply structs shared by
//               the main memory controller and its request queue.
// Revision    : 1.0 - initial release
// ============================================================================
package main_mem_ctrl_pkg;

  localparam int c_noc_node_w = 8;
  localparam int c_noc_len_w  = 16;
  localparam int c_noc_dat_w  = 184;
  localparam int c_line_bytes = 16;

  typedef enum logic [7:0] {
    memory_read_request  = 8'h01,
    memory_read_reply    = 8'h02,
    memory_write_request = 8'h03
  } noc_pkt_type_e;

  typedef struct packed {
    logic [c_noc_len_w-1:0]  len;
    logic [c_noc_node_w-1:0] src_addr;
    logic [c_noc_node_w-1:0] src_port;
    logic [c_noc_node_w-1:0] dst_addr;
    logic [c_noc_node_w-1:0] dst_port;
  } noc_hdr_t;

  typedef struct packed {
    noc_hdr_t                hdr;
    logic [c_noc_dat_w-1:0]  dat;
  } noc_pkt_t;

  // Packed LSB-first: the type byte sits at dat[7:0] in every layout.
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  typ;
  } mem_rd_rq;

  typedef struct packed {
    logic [15:0]                 wmsk;
    logic [c_line_bytes*8-1:0]   line;
    logic [31:0]                 addr;
    logic [7:0]                  typ;
  } mem_wr_rq;

  typedef struct packed {
    logic [31:0]                 req_addr;
    logic [c_line_bytes*8-1:0]   line;
    logic [7:0]                  typ;
  } mem_rd_rp;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_REPLY  = 2'd2
  } mem_state_e;

  localparam logic [c_noc_len_w-1:0] c_rd_rp_len =
    c_noc_len_w'($bits(noc_hdr_t) + $bits(mem_rd_rp));

endpackage
`default_nettype wire

// File: rtl/main_mem_ctrl_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_fifo
// Description : In-order request queue holding complete NOC packets.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_fifo
  import main_mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  noc_pkt_t i_data,
  input  logic     i_pop,
  output noc_pkt_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int c_ptr_w = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [c_ptr_w:0] r_wr_ptr;
  logic [c_ptr_w:0] r_rd_ptr;
  noc_pkt_t         r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[c_ptr_w-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_ptr_w+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_ptr_w+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_ptr_w-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/main_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : main_mem_ctrl
// Description : NOC endpoint serving line reads/writes from a fixed-latency
//               byte-addressed store, one request at a time in arrival order.
// Revision    : 1.0 - initial release
// ============================================================================
module main_mem_ctrl
  import main_mem_ctrl_pkg::*;
#(
  parameter int MEM_BYTES = 65536,
  parameter int MEM_LAT   = 2,
  parameter int Q_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_av,
  input  noc_pkt_t                rx_dat,
  output logic                    rx_re,
  output logic                    tx_av,
  output noc_pkt_t                tx_dat,
  input  logic                    tx_re,
  input  logic [c_noc_node_w-1:0] prt_addr,
  input  logic [c_noc_node_w-1:0] prt_num,
  output logic [7:0]              drop_cnt
);

  localparam int c_aw = $clog2(MEM_BYTES);
  localparam int c_cw = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [c_cw-1:0] c_cnt_init = c_cw'(MEM_LAT - 1);

  mem_state_e                  r_state;
  mem_state_e                  w_state_nxt;
  logic [c_cw-1:0]             r_cnt;
  noc_pkt_t                    r_req;
  noc_pkt_t                    w_q_head;
  noc_pkt_t                    w_reply;
  mem_wr_rq                    w_wr;
  mem_rd_rp                    w_rp;
  logic                        w_q_full;
  logic                        w_q_empty;
  logic                        w_push;
  logic                        w_deq;
  logic                        w_done;
  logic                        w_is_rd;
  logic                        w_is_wr;
  logic                        w_mem_we;
  logic [c_aw-1:0]             w_base;
  logic [c_line_bytes*8-1:0]   w_rd_line;
  logic [7:0]                  r_store [MEM_BYTES];
  logic                        w_unused;

  assign rx_re  = rst && !w_q_full;
  assign w_push = rx_av && rx_re;

  mem_req_fifo #(
    .DEPTH (Q_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (rx_dat),
    .i_pop   (w_deq),
    .o_data  (w_q_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  // Read and write requests share the type/address layout, so one view serves both.
  assign w_wr     = mem_wr_rq'(r_req.dat);
  assign w_is_rd  = (w_wr.typ == memory_read_request);
  assign w_is_wr  = (w_wr.typ == memory_write_request);
  assign w_base   = c_aw'(w_wr.addr) & ~c_aw'(c_line_bytes - 1);
  assign w_done   = (r_state == ST_ACCESS) && (r_cnt == '0);
  assign w_mem_we = w_done && w_is_wr;
  assign tx_av    = (r_state == ST_REPLY);
  assign w_unused = ^{prt_addr, prt_num, r_req.hdr.len};

  always_comb begin
    w_rd_line = '0;
    for (int i = 0; i < c_line_bytes; i++) begin
      w_rd_line[8*i +: 8] = r_store[w_base + c_aw'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < c_line_bytes; i++) begin
        if (w_wr.wmsk[i]) r_store[w_base + c_aw'(i)] <= w_wr.line[8*i +: 8];
      end
    end
  end

  // Reply goes back to the requester, appearing to come from the node it addressed.
  always_comb begin
    w_rp.req_addr         = w_wr.addr;
    w_rp.line             = w_rd_line;
    w_rp.typ              = memory_read_reply;
    w_reply               = '0;
    w_reply.hdr.len       = c_rd_rp_len;
    w_reply.hdr.src_addr  = r_req.hdr.dst_addr;
    w_reply.hdr.src_port  = r_req.hdr.dst_port;
    w_reply.hdr.dst_addr  = r_req.hdr.src_addr;
    w_reply.hdr.dst_port  = r_req.hdr.src_port;
    w_reply.dat[$bits(mem_rd_rp)-1:0] = w_rp;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_deq       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_q_empty) begin
          w_deq       = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == '0) w_state_nxt = w_is_rd ? ST_REPLY : ST_IDLE;
      end
      ST_REPLY: begin
        if (tx_re) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req    <= '0;
      r_cnt    <= '0;
      tx_dat   <= '0;
      drop_cnt <= '0;
    end else begin
      if (w_deq) begin
        r_req <= w_q_head;
        r_cnt <= c_cnt_init;
      end else if ((r_state == ST_ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - c_cw'(1);
      end
      if (w_done && w_is_rd) tx_dat <= w_reply;
      if (w_done && !w_is_rd && !w_is_wr && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_main_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_mem_ctrl
// Description : Scoreboard bench for main_mem_ctrl with a byte-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_mem_ctrl;
  import main_mem_ctrl_pkg::*;

  localparam int MEM_BYTES = 65536;
  localparam int MEM_LAT   = 2;
  localparam int Q_DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_av = 1'b0;
  noc_pkt_t   rx_dat = '0;
  logic       tx_re = 1'b0;
  logic [7:0] prt_addr = 8'h21;
  logic [7:0] prt_num  = 8'h03;
  logic       rx_re;
  logic       tx_av;
  noc_pkt_t   tx_dat;
  logic [7:0] drop_cnt;

  main_mem_ctrl #(
    .MEM_BYTES (MEM_BYTES),
    .MEM_LAT   (MEM_LAT),
    .Q_DEPTH   (Q_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_av    (rx_av),
    .rx_dat   (rx_dat),
    .rx_re    (rx_re),
    .tx_av    (tx_av),
    .tx_dat   (tx_dat),
    .tx_re    (tx_re),
    .prt_addr (prt_addr),
    .prt_num  (prt_num),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    noc_pkt_t pkt;
    int       due;
  } exp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  logic [7:0]  ref_mem [int];
  int          ref_drop = 0;
  bit          stall = 1'b0;
  bit          seen = 1'b0;
  noc_pkt_t    held;

  task automatic check(input string nm, input logic [231:0] act, input logic [231:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: drives tx_re and checks each reply once, then its stability while stalled.
  always @(negedge clk) begin : mon
    exp_t e;
    tx_re = !stall;
    if (!rst) begin
      seen = 1'b0;
    end else if (tx_av) begin
      if (!seen) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_reply: got %h expected none", tx_dat);
        end else begin
          e = sb.pop_front();
          check("reply_pkt", tx_dat, e.pkt);
          if (e.due >= 0) check("reply_latency", cyc, e.due);
        end
        seen = 1'b1;
        held = tx_dat;
      end else begin
        check("reply_stable", tx_dat, held);
      end
      if (tx_re) seen = 1'b0;
    end
  end

  function automatic noc_pkt_t mk_pkt(input logic [7:0] typ, input logic [31:0] addr,
                                      input logic [127:0] line, input logic [15:0] wmsk);
    noc_pkt_t p;
    p.hdr.len      = 16'($urandom);
    p.hdr.src_addr = 8'($urandom);
    p.hdr.src_port = 8'($urandom);
    p.hdr.dst_addr = 8'($urandom);
    p.hdr.dst_port = 8'($urandom);
    p.dat          = {wmsk, line, addr, typ};
    return p;
  endfunction

  // Reference model: applies the request to a byte map in arrival order.
  task automatic model(input noc_pkt_t p, input int acc, input bit lat);
    logic [7:0]   typ;
    logic [31:0]  addr;
    logic [127:0] line;
    logic [15:0]  wmsk;
    logic [127:0] d;
    int           base;
    exp_t         e;
    typ  = p.dat[7:0];
    addr = p.dat[39:8];
    line = p.dat[167:40];
    wmsk = p.dat[183:168];
    base = int'((addr & 32'hFFFF_FFF0) % MEM_BYTES);
    if (typ == 8'h01) begin
      for (int i = 0; i < 16; i++) d[8*i +: 8] = ref_mem[base + i];
      e.pkt              = '0;
      e.pkt.hdr.len      = 16'($bits(noc_hdr_t) + 32 + 128 + 8);
      e.pkt.hdr.src_addr = p.hdr.dst_addr;
      e.pkt.hdr.src_port = p.hdr.dst_port;
      e.pkt.hdr.dst_addr = p.hdr.src_addr;
      e.pkt.hdr.dst_port = p.hdr.src_port;
      e.pkt.dat[167:0]   = {addr, d, 8'h02};
      e.due              = lat ? acc + 1 + MEM_LAT : -1;
      sb.push_back(e);
    end else if (typ == 8'h03) begin
      for (int i = 0; i < 16; i++) if (wmsk[i]) ref_mem[base + i] = line[8*i +: 8];
    end else if (ref_drop < 255) begin
      ref_drop++;
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input noc_pkt_t p, input bit lat, output int waited);
    waited = 0;
    rx_dat = p;
    rx_av  = 1'b1;
    while (!rx_re && waited < 200) begin
      @(negedge clk);
      waited++;
      if (waited == 8) stall = 1'b0;
    end
    if (!rx_re) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got rx_re=%0b expected 1", rx_re);
    end else begin
      model(p, cyc + 1, lat);
    end
    @(negedge clk);
    rx_av = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || tx_av) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    repeat (Q_DEPTH * (MEM_LAT + 1) + 4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          w;
    int          wsum;
    noc_pkt_t    p6;
    logic [31:0] lines [8];
    logic [31:0] a;
    int          r;

    repeat (3) @(negedge clk);
    check("rst_rx_re", rx_re, 0);
    check("rst_tx_av", tx_av, 0);
    check("rst_tx_dat", tx_dat, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b1;
    #1;
    check("post_rst_rx_re", rx_re, 1);
    @(negedge clk);

    // Full write, then read with latency check
    send(mk_pkt(8'h03, 32'h40, 128'h0123456789ABCDEF_FEDCBA9876543210, 16'hFFFF), 0, w);
    repeat (8) @(negedge clk);
    send(mk_pkt(8'h01, 32'h40, '0, '0), 1, w);
    drain();

    // Partial write keeps bytes 0..3
    send(mk_pkt(8'h03, 32'h40, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, 16'hFFF0), 0, w);
    send(mk_pkt(8'h01, 32'h40, '0, '0), 0, w);
    drain();

    // Unaligned read returns the aligned line and the original address
    send(mk_pkt(8'h01, 32'h4A, '0, '0), 1, w);
    drain();

    // Unknown type dropped; following read unaffected
    send(mk_pkt(8'hEE, 32'h40, '0, '0), 0, w);
    send(mk_pkt(8'h01, 32'h44, '0, '0), 0, w);
    drain();
    check("drop_one", drop_cnt, ref_drop);

    // Back-pressure: 1 in service + Q_DEPTH queued, then rx_re drops
    stall = 1'b1;
    wsum = 0;
    for (int k = 0; k < 5; k++) begin
      send(mk_pkt(8'h01, 32'h40 + 32'(k), '0, '0), 0, w);
      wsum += w;
    end
    check("bp_accept5", wsum, 0);
    p6 = mk_pkt(8'h01, 32'h4F, '0, '0);
    rx_dat = p6;
    rx_av  = 1'b1;
    repeat (6) @(negedge clk);
    check("bp_rx_re_low", rx_re, 0);
    check("bp_tx_av_held", tx_av, 1);
    stall = 1'b0;
    send(p6, 0, w);
    drain();
    check("bp_sb_empty", sb.size(), 0);

    // Randomized traffic over a few lines with random mirroring of the upper address bits
    for (int k = 0; k < 8; k++) begin
      lines[k] = 32'($urandom_range(0, 4095)) << 4;
      send(mk_pkt(8'h03, ($urandom & 32'hFFFF_0000) | lines[k],
                  {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF), 0, w);
    end
    for (int n = 0; n < 250; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 99);
      a = ($urandom & 32'hFFFF_0000) | lines[$urandom_range(0, 7)] | 32'($urandom_range(0, 15));
      if (r < 45)
        send(mk_pkt(8'h01, a, '0, '0), 0, w);
      else if (r < 85)
        send(mk_pkt(8'h03, a, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom)), 0, w);
      else if (r < 90)
        send(mk_pkt(8'h02, a, '0, '0), 0, w);
      else
        send(mk_pkt(8'($urandom_range(4, 255)), a, '0, '0), 0, w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    stall = 1'b0;
    drain();
    check("rand_drop_cnt", drop_cnt, ref_drop);

    // Saturation of the drop counter
    for (int k = 0; k < 260; k++) send(mk_pkt(8'hEE, 32'h0, '0, '0), 0, w);
    drain();
    check("drop_saturate", drop_cnt, ref_drop);

    // Reset while a reply is stalled with more requests queued
    stall = 1'b1;
    send(mk_pkt(8'h01, 32'h40, '0, '0), 0, w);
    send(mk_pkt(8'h01, 32'h44, '0, '0), 0, w);
    send(mk_pkt(8'h01, 32'h48, '0, '0), 0, w);
    w = 0;
    while (!tx_av && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("stall_tx_av", tx_av, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_tx_av", tx_av, 0);
    check("midrst_rx_re", rx_re, 0);
    sb.delete();
    ref_drop = 0;
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    stall = 1'b0;
    #1;
    check("midrst_release_rx_re", rx_re, 1);
    check("midrst_drop_cnt", drop_cnt, 0);
    repeat (12) @(negedge clk);
    check("midrst_queue_empty", tx_av, 0);
    send(mk_pkt(8'h01, 32'h40, '0, '0), 1, w);
    drain();

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/main_mem_ctrl.md
# main_mem_ctrl

NOC-attached main memory controller that sits directly downstream of `mem_acc_cont` across the NOC. It accepts `memory_read_request` and `memory_write_request` packets from the NOC, buffers them in order, and accesses an internal byte-addressed backing store with fixed latency. It returns a `memory_read_reply` packet for every read. This block replaces the combinational memory/NOC emulation used in benches with a cycle-accurate, back-pressured endpoint.

## Interface
- `MEM_BYTES`, 65536: backing store size in bytes; power of two, at least 16.
- `MEM_LAT`, 2: array access latency in cycles; at least 1.
- `Q_DEPTH`, 4: request queue depth; power of two, at least 2.
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset; asynchronous and active-low.
- `noc_port`  `noc_ip_port.ip_side`  -  NOC endpoint.
  - Inputs: `rx_av`, `rx_dat`, `tx_re`, `prt_addr`, `prt_num`.
  - Outputs: `rx_re`, `tx_av`, `tx_dat`.
- `drop_cnt`  out  8  saturating count of dropped packets with an unknown type.

## Operation
- **Request queue (`mem_req_fifo`)**
  - `rx_re = !full`.
  - A packet transfers on a posedge where `rx_av && rx_re`.
  - The full header and `dat` are stored.
- **Packet decode** (`dat[7:0]` is the type)
  - Read: `dat[8+:32]` is the address.
  - Write: `dat[8+:32]` is the address, `dat[40+:128]` is the line, `dat[168+:16]` is `wmsk`.
  - Any other type is dequeued and discarded, and `drop_cnt` increments, saturating at 255.
- **Addressing**
  - The line base is `{addr[31:4], 4'b0}`, taken modulo `MEM_BYTES`.
  - The low 4 address bits are ignored.
  - Byte `i` of the line is at `base+i`; there is no wrap inside a line.
- **FSM states**
  - `IDLE`: if the queue is non-empty, dequeue, latch the entry, load `cnt=MEM_LAT-1`, go to `ACCESS`.
  - `ACCESS`: decrement `cnt`. When `cnt==0`:
    - write: commit bytes whose `wmsk[i]` is set, go to `IDLE`;
    - read: capture the 16 bytes, build the reply, go to `REPLY`;
    - unknown type: go to `IDLE`.
  - `REPLY`: hold `tx_av=1` with `tx_dat` stable until `tx_re` is sampled high, then go to `IDLE`.
- **Read reply construction**
  - `hdr.src_addr/src_port` = request `dst_addr/dst_port`.
  - `hdr.dst_addr/dst_port` = request `src_addr/src_port`.
  - `hdr.len = $bits(hdr)+$bits(mem_rd_rp)`.
  - `dat[7:0]=memory_read_reply`, `dat[8+:128]` = line data, `dat[136+:32]` = the original request address, unmodified.
- **Ordering and write semantics**
  - Strict in-order processing, so a read issued after a write to the same line returns the written data.
  - Writes are posted; no reply is sent.
- **Backing store and reset**
  - Store contents are unaffected by reset and undefined at power-up.

## Timing
- **Reset values:** `rx_re=0` while reset is asserted, then `1` after reset (queue empty); `tx_av=0`, `tx_dat=0`, `drop_cnt=0`; FSM in `IDLE`; queue empty.
- **Reset asserted mid-operation:** any in-flight reply and all queued requests are discarded. A write that was already committed remains in the store.
- **Read latency:**
  - Request accepted at edge E0, dequeued at E1.
  - `tx_av` goes high after edge E1+`MEM_LAT`, i.e. 1+`MEM_LAT` cycles after acceptance.
  - With the default `MEM_LAT=2`, `tx_av` is high 3 cycles after acceptance.
- **Write commit:** the store updates at edge E1+`MEM_LAT`.
- **Throughput:** one request per `1+MEM_LAT` cycles, plus any reply stall.
- **Queue boundaries:**
  - Enqueue and dequeue in the same cycle are both permitted.
  - When full, `rx_re=0` and no bypass occurs.
  - Pointers wrap modulo `Q_DEPTH`.
- **Reply stall:** while `tx_re=0` the FSM holds in `REPLY`. The queue keeps accepting requests until full.

## Structure
- Shared package (`defines.svh`):
  - add `memory_write_request` to the NOC packet-type enum;
  - define `mem_rd_rq`, `mem_wr_rq`, `mem_rd_rp` packed structs matching the field offsets above.
- One sub-module: `mem_req_fifo` (parameter `DEPTH`, payload = NOC packet type).
- The FSM and backing array live in `main_mem_ctrl`.

## Test plan
- **Write then read:** write addr `0x40`, line `0x0123…EF`, `wmsk=16'hFFFF`; then read `0x40`.
  - Reply carries the same line with `dat[136+:32]=0x40`.
  - Header src/dst are swapped.
  - `tx_av` rises 3 cycles after the read is accepted.
- **Partial write:** write `0x40` with `wmsk=16'hFFF0` and new data, then read `0x40`.
  - Bytes 0–3 keep the old data; bytes 4–15 take the new data.
- **Unaligned read:** read addr `0x4A` → reply data is the `0x40` line and `dat[136+:32]=0x4A`.
- **Back-pressure:** hold `tx_re=0` and send 6 reads back-to-back.
  - `rx_re` drops after 5 acceptances (1 in service + 4 queued).
  - Releasing `tx_re` drains 5 replies in order.
- **Unknown type:** send type `0xEE` → no reply, `drop_cnt=1`, and a following read is unaffected.
- **Reset mid-stall:** assert `rst` low during `REPLY`.
  - `tx_av=0` immediately.
  - The queue is empty after release.
  - Previously committed data still reads back.
